dma_ring_sched: RTL and testbench

- Hardware command scheduler that feeds the simple_dma controller with buffer descriptors, replacing software-driven per-buffer START pulses.
- Carves a ring of equal-size line buffers out of the SDRAM DMA allocation and issues START/START_ADR/BUF_SIZE with bounded outstanding commands.
- Tracks completion through simple_dma DONE_CNT and, in cyclic mode, throttles on a software read counter so unread buffers are never overwritten.
- Sits in the CLK_80 bus-clock domain between the HPS control registers and simple_dma.

---
 rtl/dma_ring_sched.sv | 198 +++++++++++++++++++
 tb/tb_dma_ring_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ring_sched.sv
// dma_ring_sched
//   Hardware command scheduler for simple_dma. Carves a ring of equal-size
//   line buffers out of the SDRAM DMA window and issues START/ADR/SIZE
//   commands with a bounded number of commands in flight. Completion is
//   tracked through simple_dma's cumulative DONE_CNT. In cyclic mode, issue
//   is throttled against the software read counter, so unread buffers are
//   never overwritten.
//
// Ports
//   CLK, SRST_N             bus clock, synchronous active-low reset
//   ENABLE                  level; a rising edge in IDLE latches config, starts
//   MODE_CYCLIC             1 = endless ring with SW flow control, 0 = one-shot
//   RING_BASE, BUF_SIZE     ring start word address, words per buffer
//   RING_BUFS, BUF_COUNT    buffers in ring, buffers for a one-shot run
//   SW_RD_CNT               cumulative buffers consumed by software
//   DMA_START/ADR/SIZE      command pulse and payload to simple_dma
//   DMA_DONE_CNT            simple_dma cumulative completed-buffer count
//   ISSUED_CNT, DONE_CNT    commands issued / buffers completed since start
//   BUSY, BLOCKED           running; cyclic issue stalled on a full ring
//   FINISHED, ERR           one-shot complete; sticky config/protocol error
module dma_ring_sched #(
  parameter int ADR_W     = 28,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 2
) (
  input  logic             CLK,
  input  logic             SRST_N,
  input  logic             ENABLE,
  input  logic             MODE_CYCLIC,
  input  logic [ADR_W-1:0] RING_BASE,
  input  logic [ADR_W-1:0] BUF_SIZE,
  input  logic [CNT_W-1:0] RING_BUFS,
  input  logic [CNT_W-1:0] BUF_COUNT,
  input  logic [CNT_W-1:0] SW_RD_CNT,
  output logic             DMA_START,
  output logic [ADR_W-1:0] DMA_ADR,
  output logic [ADR_W-1:0] DMA_SIZE,
  input  logic [CNT_W-1:0] DMA_DONE_CNT,
  output logic [CNT_W-1:0] ISSUED_CNT,
  output logic [CNT_W-1:0] DONE_CNT,
  output logic             BUSY,
  output logic             BLOCKED,
  output logic             FINISHED,
  output logic             ERR
);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_OUTST_C = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  // Largest ring that still leaves headroom for the in-flight window
  // before the modular occupancy arithmetic becomes ambiguous.
  localparam logic [CNT_W-1:0] RING_LIMIT  = {CNT_W{1'b1}} - MAX_OUTST_C;

  state_t state, state_nxt;

  logic             en_prev;
  logic             aborted;
  logic             cyclic_q;
  logic [ADR_W-1:0] base_q;
  logic [ADR_W-1:0] size_q;
  logic [CNT_W-1:0] ring_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] done_base;
  logic [ADR_W-1:0] cur_adr;
  logic [CNT_W-1:0] idx;

  logic             start_go;
  logic             cfg_err;
  logic             zero_run;
  logic [CNT_W-1:0] outst;
  logic             outst_ok;
  logic             ring_ok;
  logic             count_ok;
  logic             issue_ok;
  logic             ring_full;
  logic             do_issue;
  logic             running;

  assign start_go = (state == IDLE) && ENABLE && !en_prev;
  assign cfg_err  = (BUF_SIZE == '0) ||
                    (MODE_CYCLIC && ((RING_BUFS == '0) || (RING_BUFS > RING_LIMIT)));
  assign zero_run = !MODE_CYCLIC && (BUF_COUNT == '0);

  // All occupancy arithmetic is modular so it stays correct across wrap.
  assign outst     = ISSUED_CNT - DONE_CNT;
  assign outst_ok  = outst < MAX_OUTST_C;
  assign ring_ok   = (ISSUED_CNT - SW_RD_CNT) < ring_q;
  assign count_ok  = ISSUED_CNT < count_q;
  assign issue_ok  = outst_ok && (cyclic_q ? ring_ok : count_ok);
  assign ring_full = cyclic_q && outst_ok && !ring_ok;

  assign running = (state == ISSUE) || (state == GAP) ||
                   (state == WAIT)  || (state == DRAIN);
  assign BUSY    = running;
  assign BLOCKED = (state == ISSUE) && ring_full;

  always_comb begin
    state_nxt = state;
    do_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) begin
          if (cfg_err || zero_run) state_nxt = DONE;
          else                     state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!ENABLE) begin
          state_nxt = DRAIN;
        end else if (issue_ok) begin
          state_nxt = GAP;
          do_issue  = 1'b1;
        end
      end
      // simple_dma accepts at most one START every two cycles.
      GAP: begin
        state_nxt = ENABLE ? WAIT : DRAIN;
      end
      // A ring-full stall is parked in ISSUE so that it is visible on BLOCKED.
      WAIT: begin
        if (!ENABLE)                                state_nxt = DRAIN;
        else if (!cyclic_q && ISSUED_CNT == count_q) state_nxt = DRAIN;
        else if (issue_ok || ring_full)             state_nxt = ISSUE;
      end
      DRAIN: begin
        if (DONE_CNT == ISSUED_CNT) state_nxt = DONE;
      end
      DONE: begin
        if (!ENABLE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      state      <= IDLE;
      en_prev    <= 1'b0;
      aborted    <= 1'b0;
      DMA_START  <= 1'b0;
      DMA_ADR    <= '0;
      DMA_SIZE   <= '0;
      ISSUED_CNT <= '0;
      DONE_CNT   <= '0;
      FINISHED   <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state     <= state_nxt;
      en_prev   <= ENABLE;
      DMA_START <= do_issue;
      if (do_issue) begin
        DMA_ADR    <= cur_adr;
        DMA_SIZE   <= size_q;
        ISSUED_CNT <= ISSUED_CNT + CNT_ONE;
      end
      if (start_go) begin
        ISSUED_CNT <= '0;
        DONE_CNT   <= '0;
        ERR        <= cfg_err;
        FINISHED   <= !cfg_err && zero_run;
        aborted    <= 1'b0;
      end else if (running) begin
        DONE_CNT <= DMA_DONE_CNT - done_base;
        // Completions overtaking issues indicate a protocol fault upstream.
        if (outst > MAX_OUTST_C) ERR <= 1'b1;
        if (state != DRAIN && !ENABLE) aborted <= 1'b1;
        if (state == DRAIN && state_nxt == DONE) FINISHED <= !cyclic_q && !aborted;
      end else if (state == DONE && !ENABLE) begin
        FINISHED <= 1'b0;
      end
    end
  end

  // Config latch and ring address generation; only meaningful while running.
  always_ff @(posedge CLK) begin
    if (start_go) begin
      cyclic_q  <= MODE_CYCLIC;
      base_q    <= RING_BASE;
      size_q    <= BUF_SIZE;
      ring_q    <= RING_BUFS;
      count_q   <= BUF_COUNT;
      done_base <= DMA_DONE_CNT;
      cur_adr   <= RING_BASE;
      idx       <= '0;
    end else if (do_issue) begin
      // A one-shot run with RING_BUFS == 0 advances linearly forever.
      if ((ring_q != '0) && ((idx + CNT_ONE) == ring_q)) begin
        cur_adr <= base_q;
        idx     <= '0;
      end else begin
        cur_adr <= cur_adr + size_q;
        idx     <= idx + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dma_ring_sched.sv
module tb_dma_ring_sched;

  logic        CLK = 1'b0;
  logic        SRST_N;
  logic        ENABLE;
  logic        MODE_CYCLIC;
  logic [27:0] RING_BASE;
  logic [27:0] BUF_SIZE;
  logic [15:0] RING_BUFS;
  logic [15:0] BUF_COUNT;
  logic [15:0] SW_RD_CNT;
  logic        DMA_START;
  logic [27:0] DMA_ADR;
  logic [27:0] DMA_SIZE;
  logic [15:0] DMA_DONE_CNT;
  logic [15:0] ISSUED_CNT;
  logic [15:0] DONE_CNT;
  logic        BUSY;
  logic        BLOCKED;
  logic        FINISHED;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_ring_sched #(.ADR_W(28), .CNT_W(16), .MAX_OUTST(2)) dut (
    .CLK(CLK), .SRST_N(SRST_N), .ENABLE(ENABLE), .MODE_CYCLIC(MODE_CYCLIC),
    .RING_BASE(RING_BASE), .BUF_SIZE(BUF_SIZE), .RING_BUFS(RING_BUFS),
    .BUF_COUNT(BUF_COUNT), .SW_RD_CNT(SW_RD_CNT), .DMA_START(DMA_START),
    .DMA_ADR(DMA_ADR), .DMA_SIZE(DMA_SIZE), .DMA_DONE_CNT(DMA_DONE_CNT),
    .ISSUED_CNT(ISSUED_CNT), .DONE_CNT(DONE_CNT), .BUSY(BUSY),
    .BLOCKED(BLOCKED), .FINISHED(FINISHED), .ERR(ERR)
  );

  // simple_dma stand-in: serial completion after a programmable latency.
  logic [15:0] model_cnt;
  logic [15:0] cnt_ofs;
  logic [15:0] sw_rd;
  bit          sw_follow;
  bit          model_clr;
  bit          model_en;
  int          lat_min, lat_max;
  int          pend, timer, n_starts, max_pend;
  logic [27:0] adr_log [0:63];

  assign DMA_DONE_CNT = model_cnt + cnt_ofs;
  assign SW_RD_CNT    = sw_follow ? ISSUED_CNT : sw_rd;

  always @(posedge CLK) begin
    int p, t;
    if (model_clr) begin
      pend      <= 0;
      timer     <= 0;
      model_cnt <= '0;
      n_starts  <= 0;
      max_pend  <= 0;
    end else begin
      p = pend;
      t = timer;
      if (p > 0 && model_en) begin
        if (t > 0) t = t - 1;
        else begin
          p = p - 1;
          model_cnt <= model_cnt + 16'd1;
          t = int'($urandom_range(lat_max, lat_min));
        end
      end
      if (DMA_START) begin
        if (p == 0) t = int'($urandom_range(lat_max, lat_min));
        p = p + 1;
        adr_log[n_starts[5:0]] <= DMA_ADR;
        n_starts <= n_starts + 1;
      end
      pend  <= p;
      timer <= t;
      if (p > max_pend) max_pend <= p;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    SRST_N = 1'b0; ENABLE = 1'b0; model_clr = 1'b1; model_en = 1'b1;
    cnt_ofs = '0; sw_rd = '0; sw_follow = 1'b0;
    MODE_CYCLIC = 1'b0; RING_BASE = '0; BUF_SIZE = 28'd972;
    RING_BUFS = '0; BUF_COUNT = '0; lat_min = 2; lat_max = 4;
    repeat (2) @(negedge CLK);
    SRST_N = 1'b1; model_clr = 1'b0;
  endtask

  task automatic start_run(input bit cyc, input logic [27:0] base, input logic [27:0] size,
                           input logic [15:0] rb, input logic [15:0] cnt);
    @(negedge CLK);
    MODE_CYCLIC = cyc; RING_BASE = base; BUF_SIZE = size;
    RING_BUFS = rb; BUF_COUNT = cnt; ENABLE = 1'b1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (!BUSY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({DMA_START, DMA_ADR, DMA_SIZE, ISSUED_CNT, DONE_CNT, BUSY, BLOCKED, FINISHED, ERR} !== 93'd0) begin
      errors++;
      $display("FAIL reset_outputs got start=%b adr=%0d size=%0d iss=%0d done=%0d busy=%b blk=%b fin=%b err=%b want all 0",
               DMA_START, DMA_ADR, DMA_SIZE, ISSUED_CNT, DONE_CNT, BUSY, BLOCKED, FINISHED, ERR);
    end
  endtask

  task automatic test_oneshot();
    bit ok;
    do_reset();
    lat_min = 10; lat_max = 150;
    start_run(1'b0, 28'd0, 28'd972, 16'd0, 16'd32);
    @(negedge CLK);
    checks++;
    if (DMA_START !== 1'b0 || BUSY !== 1'b1) begin errors++;
      $display("FAIL oneshot_cycle1 got start=%b busy=%b want start=0 busy=1", DMA_START, BUSY); end
    @(negedge CLK);
    checks++;
    if (DMA_START !== 1'b1 || DMA_ADR !== 28'd0 || DMA_SIZE !== 28'd972) begin errors++;
      $display("FAIL oneshot_first_start got start=%b adr=%0d size=%0d want 1 0 972", DMA_START, DMA_ADR, DMA_SIZE); end
    wait_idle(20000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL oneshot_timeout got busy=%b want 0", BUSY); end
    checks++;
    if (n_starts !== 32) begin errors++; $display("FAIL oneshot_starts got %0d want 32", n_starts); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (adr_log[i] !== 28'(i * 972)) begin errors++;
        $display("FAIL oneshot_adr[%0d] got %0d want %0d", i, adr_log[i], i * 972); end
    end
    checks++;
    if (max_pend !== 2) begin errors++; $display("FAIL oneshot_max_outst got %0d want 2", max_pend); end
    checks++;
    if (FINISHED !== 1'b1 || DONE_CNT !== 16'd32 || ISSUED_CNT !== 16'd32 || ERR !== 1'b0) begin errors++;
      $display("FAIL oneshot_final got fin=%b done=%0d iss=%0d err=%b want 1 32 32 0", FINISHED, DONE_CNT, ISSUED_CNT, ERR); end
    ENABLE = 1'b0;
  endtask

  task automatic test_zero_count();
    do_reset();
    start_run(1'b0, 28'd0, 28'd972, 16'd0, 16'd0);
    repeat (3) @(negedge CLK);
    checks++;
    if (FINISHED !== 1'b1 || ERR !== 1'b0 || BUSY !== 1'b0 || n_starts !== 0) begin errors++;
      $display("FAIL zero_count got fin=%b err=%b busy=%b starts=%0d want 1 0 0 0", FINISHED, ERR, BUSY, n_starts); end
    ENABLE = 1'b0;
  endtask

  task automatic test_cyclic_wrap();
    bit ok;
    do_reset();
    sw_follow = 1'b1;
    start_run(1'b1, 28'd0, 28'd972, 16'd4, 16'd0);
    for (int c = 0; c < 2000 && n_starts < 10; c++) @(negedge CLK);
    ENABLE = 1'b0;
    wait_idle(2000, ok);
    checks++;
    if (ok !== 1'b1 || n_starts < 10) begin errors++;
      $display("FAIL cyclic_progress got starts=%0d idle=%b want >=10 1", n_starts, ok); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (adr_log[i] !== 28'((i % 4) * 972)) begin errors++;
        $display("FAIL cyclic_adr[%0d] got %0d want %0d", i, adr_log[i], (i % 4) * 972); end
    end
    checks++;
    if (ERR !== 1'b0 || FINISHED !== 1'b0) begin errors++;
      $display("FAIL cyclic_flags got err=%b fin=%b want 0 0", ERR, FINISHED); end
  endtask

  task automatic test_flow_control();
    bit ok, seen;
    do_reset();
    start_run(1'b1, 28'd0, 28'd972, 16'd4, 16'd0);
    for (int c = 0; c < 300 && BLOCKED !== 1'b1; c++) @(negedge CLK);
    repeat (20) @(negedge CLK);
    checks++;
    if (BLOCKED !== 1'b1 || n_starts !== 4) begin errors++;
      $display("FAIL flow_blocked got blk=%b starts=%0d want 1 4", BLOCKED, n_starts); end
    sw_rd = 16'd1;
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      if (DMA_START === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || BLOCKED !== 1'b0) begin errors++;
      $display("FAIL flow_release got start_seen=%b blk=%b want 1 0", seen, BLOCKED); end
    repeat (40) @(negedge CLK);
    checks++;
    if (n_starts !== 5 || BLOCKED !== 1'b1 || adr_log[4] !== 28'd0) begin errors++;
      $display("FAIL flow_one_more got starts=%0d blk=%b adr4=%0d want 5 1 0", n_starts, BLOCKED, adr_log[4]); end
    ENABLE = 1'b0;
    wait_idle(500, ok);
    checks++;
    if (ok !== 1'b1 || FINISHED !== 1'b0 || DONE_CNT !== 16'd5) begin errors++;
      $display("FAIL flow_stop got idle=%b fin=%b done=%0d want 1 0 5", ok, FINISHED, DONE_CNT); end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    lat_min = 30; lat_max = 30;
    start_run(1'b0, 28'd0, 28'd972, 16'd0, 16'd10);
    for (int c = 0; c < 500 && n_starts < 3; c++) @(negedge CLK);
    ENABLE = 1'b0;
    checks++;
    if (pend !== 2) begin errors++; $display("FAIL abort_outst got %0d want 2", pend); end
    wait_idle(500, ok);
    repeat (10) @(negedge CLK);
    checks++;
    if (ok !== 1'b1 || n_starts !== 3 || ISSUED_CNT !== 16'd3 || DONE_CNT !== 16'd3 || FINISHED !== 1'b0) begin errors++;
      $display("FAIL abort_drain got idle=%b starts=%0d iss=%0d done=%0d fin=%b want 1 3 3 3 0",
               ok, n_starts, ISSUED_CNT, DONE_CNT, FINISHED); end
    // Reset while the first command pulse is out (GAP state).
    do_reset();
    start_run(1'b0, 28'd100, 28'd972, 16'd0, 16'd5);
    repeat (2) @(negedge CLK);
    checks++;
    if (DMA_START !== 1'b1 || DMA_ADR !== 28'd100) begin errors++;
      $display("FAIL gap_precond got start=%b adr=%0d want 1 100", DMA_START, DMA_ADR); end
    SRST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({DMA_START, DMA_ADR, DMA_SIZE, ISSUED_CNT, DONE_CNT, BUSY, BLOCKED, FINISHED, ERR} !== 93'd0) begin
      errors++;
      $display("FAIL gap_reset got start=%b adr=%0d size=%0d iss=%0d busy=%b want all 0",
               DMA_START, DMA_ADR, DMA_SIZE, ISSUED_CNT, BUSY);
    end
    SRST_N = 1'b1; ENABLE = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    start_run(1'b0, 28'd0, 28'd0, 16'd0, 16'd4);
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b0 || FINISHED !== 1'b0 || n_starts !== 0) begin errors++;
      $display("FAIL err_size0 got err=%b busy=%b fin=%b starts=%0d want 1 0 0 0", ERR, BUSY, FINISHED, n_starts); end
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    start_run(1'b1, 28'd0, 28'd972, 16'd65534, 16'd0);
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b0 || n_starts !== 0) begin errors++;
      $display("FAIL err_ring_big got err=%b busy=%b starts=%0d want 1 0 0", ERR, BUSY, n_starts); end
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    model_en = 1'b0;
    sw_follow = 1'b1;
    start_run(1'b1, 28'd0, 28'd972, 16'd4, 16'd0);
    @(negedge CLK);
    checks++;
    if (ERR !== 1'b0 || BUSY !== 1'b1) begin errors++;
      $display("FAIL err_clear_on_start got err=%b busy=%b want 0 1", ERR, BUSY); end
    for (int c = 0; c < 100 && n_starts < 2; c++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    checks++;
    if (ERR !== 1'b0 || ISSUED_CNT !== 16'd2) begin errors++;
      $display("FAIL err_before_jump got err=%b iss=%0d want 0 2", ERR, ISSUED_CNT); end
    cnt_ofs = 16'd5;
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL err_done_jump got err=%b want 1", ERR); end
    do_reset();
  endtask

  task automatic test_counter_wrap();
    logic [15:0] last;
    bit ok;
    do_reset();
    cnt_ofs = 16'd65534;
    lat_min = 5; lat_max = 10;
    start_run(1'b0, 28'd0, 28'd972, 16'd0, 16'd5);
    @(negedge CLK);
    last = 16'd0;
    for (int c = 0; c < 3000 && BUSY; c++) begin
      @(negedge CLK);
      if (DONE_CNT !== last) begin
        checks++;
        if (DONE_CNT !== 16'(last + 16'd1)) begin errors++;
          $display("FAIL wrap_step got %0d want %0d", DONE_CNT, 16'(last + 16'd1)); end
        last = DONE_CNT;
      end
    end
    ok = !BUSY;
    checks++;
    if (ok !== 1'b1 || DONE_CNT !== 16'd5 || ISSUED_CNT !== 16'd5 || FINISHED !== 1'b1 || ERR !== 1'b0) begin errors++;
      $display("FAIL wrap_final got idle=%b done=%0d iss=%0d fin=%b err=%b want 1 5 5 1 0",
               ok, DONE_CNT, ISSUED_CNT, FINISHED, ERR); end
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (FINISHED !== 1'b0) begin errors++; $display("FAIL wrap_fin_clear got %b want 0", FINISHED); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_zero_count();
    test_cyclic_wrap();
    test_flow_control();
    test_abort();
    test_errors();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
